beam_grid_engine: RTL and testbench

//   Streaming tachyon-manifold solver, parametrised successor of the fixed 141x142 splitter counter.

---
 rtl/beam_grid_engine.sv | 182 ++++++++++++++++++
 tb/tb_beam_grid_engine.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/beam_grid_engine.sv
`default_nettype none
// ============================================================================
// beam_grid_engine : streaming splitter-grid solver (split hits / timelines)
// Rev 1.0
// ============================================================================
module beam_grid_engine #(
  parameter int WIDTH     = 141,
  parameter int HEIGHT    = 142,
  parameter int BUS_W     = 32,
  parameter int START_COL = 70,
  parameter int CNT_W     = 48,
  parameter int RES_W     = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [BUS_W-1:0] data_in,
  input  logic             valid_in,
  output logic             ready,
  output logic             busy,
  output logic             finished,
  output logic [RES_W-1:0] result,
  output logic             overflow
);

  localparam int BEATS  = (WIDTH + BUS_W - 1) / BUS_W;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int ROW_W  = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int IDX_W  = $clog2(WIDTH);
  localparam int POP_W  = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_UPDATE = 3'd2,
    S_REDUCE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t             state_q;
  logic               mode_q;
  logic [BEAT_W-1:0]  beat_q;
  logic [ROW_W-1:0]   row_q;
  logic [IDX_W-1:0]   idx_q;
  logic [RES_W-1:0]   acc_q;
  logic [RES_W-1:0]   result_q;
  logic               overflow_q;
  logic [WIDTH-1:0]   grid_row_q;
  logic [CNT_W-1:0]   cnt_q [WIDTH];

  logic [WIDTH-1:0]   grid_row_d;
  logic [CNT_W-1:0]   cnt_d [WIDTH];
  logic [WIDTH-1:0]   cnt_sat;
  logic [WIDTH-1:0]   hits;
  logic [POP_W-1:0]   pop_d;
  logic [RES_W:0]     acc_pop_sum;
  logic [RES_W:0]     acc_red_sum;
  logic [RES_W-1:0]   acc_pop_d;
  logic [RES_W-1:0]   acc_red_d;

  // Per-column next count: own beam passes unless split, neighbours' splits feed in.
  for (genvar c = 0; c < WIDTH; c++) begin : g_col
    logic [CNT_W-1:0] left_in;
    logic [CNT_W-1:0] right_in;
    logic [CNT_W-1:0] own_in;
    logic [CNT_W+1:0] sum;

    if (c > 0) begin : g_left
      assign left_in = grid_row_q[c-1] ? cnt_q[c-1] : '0;
    end else begin : g_left_edge
      assign left_in = '0;
    end

    if (c < WIDTH - 1) begin : g_right
      assign right_in = grid_row_q[c+1] ? cnt_q[c+1] : '0;
    end else begin : g_right_edge
      assign right_in = '0;
    end

    assign own_in     = grid_row_q[c] ? '0 : cnt_q[c];
    assign sum        = {2'b00, own_in} + {2'b00, left_in} + {2'b00, right_in};
    assign cnt_sat[c] = |sum[CNT_W+1:CNT_W];
    assign cnt_d[c]   = cnt_sat[c] ? '1 : sum[CNT_W-1:0];
    assign hits[c]    = grid_row_q[c] & (cnt_q[c] != '0);

    assign grid_row_d[c] = (beat_q == BEAT_W'(c / BUS_W)) ? data_in[c % BUS_W]
                                                          : grid_row_q[c];
  end

  always_comb begin
    pop_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pop_d = pop_d + POP_W'(hits[i]);
    end
  end

  assign acc_pop_sum = {1'b0, acc_q} + (RES_W+1)'(pop_d);
  assign acc_red_sum = {1'b0, acc_q} + (RES_W+1)'(cnt_q[idx_q]);
  assign acc_pop_d   = acc_pop_sum[RES_W] ? '1 : acc_pop_sum[RES_W-1:0];
  assign acc_red_d   = acc_red_sum[RES_W] ? '1 : acc_red_sum[RES_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      mode_q     <= 1'b0;
      beat_q     <= '0;
      row_q      <= '0;
      idx_q      <= '0;
      acc_q      <= '0;
      result_q   <= '0;
      overflow_q <= 1'b0;
      grid_row_q <= '0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q    <= S_LOAD;
            mode_q     <= mode;
            beat_q     <= '0;
            row_q      <= '0;
            idx_q      <= '0;
            acc_q      <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
              cnt_q[i] <= (i == START_COL) ? CNT_W'(1) : '0;
            end
          end
        end
        S_LOAD: begin
          if (valid_in) begin
            grid_row_q <= grid_row_d;
            if (beat_q == BEAT_W'(BEATS - 1)) begin
              beat_q  <= '0;
              state_q <= S_UPDATE;
            end else begin
              beat_q <= beat_q + 1'b1;
            end
          end
        end
        S_UPDATE: begin
          for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
          if (!mode_q) acc_q <= acc_pop_d;
          if ((|cnt_sat) || (!mode_q && acc_pop_sum[RES_W])) overflow_q <= 1'b1;
          if (row_q == ROW_W'(HEIGHT - 1)) begin
            row_q <= '0;
            if (mode_q) begin
              idx_q   <= '0;
              state_q <= S_REDUCE;
            end else begin
              result_q <= acc_pop_d;
              state_q  <= S_DONE;
            end
          end else begin
            row_q   <= row_q + 1'b1;
            state_q <= S_LOAD;
          end
        end
        S_REDUCE: begin
          acc_q <= acc_red_d;
          if (acc_red_sum[RES_W]) overflow_q <= 1'b1;
          if (idx_q == IDX_W'(WIDTH - 1)) begin
            result_q <= acc_red_d;
            state_q  <= S_DONE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ready    = (state_q == S_LOAD);
  assign busy     = (state_q == S_LOAD) || (state_q == S_UPDATE) || (state_q == S_REDUCE);
  assign finished = (state_q == S_DONE);
  assign result   = result_q;
  assign overflow = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_beam_grid_engine.sv
`default_nettype none
// Bench for beam_grid_engine: three parameterisations driven from one stream,
// checked against a column-by-column beam-propagation model.
module tb_beam_grid_engine;

  localparam int W  = 7;
  localparam int BW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
  logic          mode = 1'b0;
  logic [BW-1:0] data_in = '0;
  logic          valid_in = 1'b0;

  logic        rdy_a, busy_a, fin_a, ovf_a;
  logic        rdy_b, busy_b, fin_b, ovf_b;
  logic        rdy_c, busy_c, fin_c, ovf_c;
  logic [15:0] res_a, res_b, res_c;

  int          sel = 0;
  logic        cur_rdy, cur_busy, cur_fin, cur_ovf;
  logic [15:0] cur_res;

  int checks = 0;
  int errors = 0;

  beam_grid_engine #(.WIDTH(W), .HEIGHT(4), .BUS_W(BW), .START_COL(3), .CNT_W(8), .RES_W(16)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .mode(mode), .data_in(data_in), .valid_in(valid_in),
    .ready(rdy_a), .busy(busy_a), .finished(fin_a), .result(res_a), .overflow(ovf_a));

  beam_grid_engine #(.WIDTH(W), .HEIGHT(2), .BUS_W(BW), .START_COL(0), .CNT_W(8), .RES_W(16)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .mode(mode), .data_in(data_in), .valid_in(valid_in),
    .ready(rdy_b), .busy(busy_b), .finished(fin_b), .result(res_b), .overflow(ovf_b));

  beam_grid_engine #(.WIDTH(W), .HEIGHT(6), .BUS_W(BW), .START_COL(3), .CNT_W(2), .RES_W(16)) dut_c (
    .clk(clk), .rst(rst), .start(start_c), .mode(mode), .data_in(data_in), .valid_in(valid_in),
    .ready(rdy_c), .busy(busy_c), .finished(fin_c), .result(res_c), .overflow(ovf_c));

  always_comb begin
    case (sel)
      1:       {cur_rdy, cur_busy, cur_fin, cur_ovf, cur_res} = {rdy_b, busy_b, fin_b, ovf_b, res_b};
      2:       {cur_rdy, cur_busy, cur_fin, cur_ovf, cur_res} = {rdy_c, busy_c, fin_c, ovf_c, res_c};
      default: {cur_rdy, cur_busy, cur_fin, cur_ovf, cur_res} = {rdy_a, busy_a, fin_a, ovf_a, res_a};
    endcase
  end

  function automatic int height_of(input int s);
    return (s == 1) ? 2 : (s == 2) ? 6 : 4;
  endfunction
  function automatic int scol_of(input int s);
    return (s == 1) ? 0 : 3;
  endfunction
  function automatic int cntw_of(input int s);
    return (s == 2) ? 2 : 8;
  endfunction

  // Beams fall row by row; a splitter sends its beam's timelines to both neighbours.
  function automatic void model(input int rows[16], input int s, input bit md,
                                output longint res, output bit ovf);
    longint cnt[W];
    longint nxt[W];
    longint cmax, acc;
    int     hits;
    cmax = (longint'(1) << cntw_of(s)) - 1;
    acc  = 0;
    ovf  = 1'b0;
    for (int c = 0; c < W; c++) cnt[c] = (c == scol_of(s)) ? 1 : 0;
    for (int r = 0; r < height_of(s); r++) begin
      hits = 0;
      for (int c = 0; c < W; c++) nxt[c] = 0;
      for (int c = 0; c < W; c++) begin
        if (((rows[r] >> c) & 1) == 1) begin
          if (cnt[c] != 0) hits++;
          if (c > 0)     nxt[c-1] += cnt[c];
          if (c < W - 1) nxt[c+1] += cnt[c];
        end else begin
          nxt[c] += cnt[c];
        end
      end
      for (int c = 0; c < W; c++) begin
        if (nxt[c] > cmax) begin nxt[c] = cmax; ovf = 1'b1; end
        cnt[c] = nxt[c];
      end
      if (!md) begin
        acc += hits;
        if (acc > 65535) begin acc = 65535; ovf = 1'b1; end
      end
    end
    if (md) begin
      for (int c = 0; c < W; c++) begin
        acc += cnt[c];
        if (acc > 65535) begin acc = 65535; ovf = 1'b1; end
      end
    end
    res = acc;
  endfunction

  task automatic pulse_start(input bit md, input bit with_valid);
    @(negedge clk);
    mode     = md;
    valid_in = with_valid;
    data_in  = 4'hF;
    case (sel)
      1:       start_b = 1'b1;
      2:       start_c = 1'b1;
      default: start_a = 1'b1;
    endcase
    @(negedge clk);
    start_a  = 1'b0;
    start_b  = 1'b0;
    start_c  = 1'b0;
    valid_in = 1'b0;
    mode     = ~md;
  endtask

  // Drive one beat and return #1 after the edge that accepted it.
  task automatic send_beat(input logic [BW-1:0] d, input bit gaps);
    int n;
    n = 0;
    if (gaps) begin
      repeat ($urandom_range(1, 3)) begin
        @(negedge clk);
        valid_in = 1'b0;
        data_in  = 4'($urandom);
      end
    end
    forever begin
      @(negedge clk);
      data_in  = d;
      valid_in = 1'b1;
      if (cur_rdy) break;
      n++;
      if (n > 50) begin
        checks++; errors++;
        $display("FAIL ready_timeout sel=%0d: ready never rose, required 1", sel);
        break;
      end
    end
    @(posedge clk);
    #1 valid_in = 1'b0;
  endtask

  task automatic send_rows(input int rows[16], input int first, input bit gaps);
    logic [BW-1:0] b0, b1;
    for (int r = first; r < height_of(sel); r++) begin
      b0 = 4'(rows[r] & 15);
      b1 = 4'(((rows[r] >> 4) & 7) | ($urandom_range(0, 1) << 3));
      send_beat(b0, gaps);
      checks++;
      if (cur_rdy !== 1'b1) begin
        errors++; $display("FAIL ready_midrow row=%0d got=%b need=1", r, cur_rdy);
      end
      send_beat(b1, gaps);
      checks++;
      if (cur_rdy !== 1'b0) begin
        errors++; $display("FAIL ready_drop row=%0d got=%b need=0", r, cur_rdy);
      end
      @(posedge clk); #1;
      if (r < height_of(sel) - 1) begin
        checks++;
        if (cur_rdy !== 1'b1) begin
          errors++; $display("FAIL ready_return row=%0d got=%b need=1", r, cur_rdy);
        end
      end
    end
  endtask

  // Called #1 after the edge that closed the final UPDATE cycle.
  task automatic wait_done(input bit md);
    int n;
    n = 0;
    while (!cur_fin && n < 100) begin
      if (cur_busy !== 1'b1) begin
        checks++; errors++; $display("FAIL busy_while_solving got=%b need=1", cur_busy);
      end
      n++;
      @(posedge clk); #1;
    end
    checks++;
    if (n != (md ? W : 0)) begin
      errors++; $display("FAIL finish_latency sel=%0d got=%0d need=%0d", sel, n, md ? W : 0);
    end
  endtask

  task automatic check_result(input int rows[16], input bit md);
    longint exp_res;
    bit     exp_ovf;
    model(rows, sel, md, exp_res, exp_ovf);
    checks++;
    if (cur_fin !== 1'b1 || cur_busy !== 1'b0 || cur_res !== 16'(exp_res) || cur_ovf !== exp_ovf) begin
      errors++;
      $display("FAIL result sel=%0d mode=%0d got fin=%b busy=%b res=%0d ovf=%b need fin=1 busy=0 res=%0d ovf=%b",
               sel, md, cur_fin, cur_busy, cur_res, cur_ovf, exp_res, exp_ovf);
    end
  endtask

  task automatic run_solve(input int rows[16], input bit md, input bit gaps, input bit start_valid);
    pulse_start(md, start_valid);
    checks++;
    if (cur_rdy !== 1'b1 || cur_busy !== 1'b1 || cur_fin !== 1'b0) begin
      errors++;
      $display("FAIL start_accept sel=%0d got rdy=%b busy=%b fin=%b need 1 1 0", sel, cur_rdy, cur_busy, cur_fin);
    end
    send_rows(rows, 0, gaps);
    wait_done(md);
    check_result(rows, md);
  endtask

  task automatic check_reset_state(input string tag);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #0;
      checks++;
      if ({cur_rdy, cur_busy, cur_fin, cur_ovf} !== 4'b0000 || cur_res !== 16'd0) begin
        errors++;
        $display("FAIL %s sel=%0d got rdy=%b busy=%b fin=%b ovf=%b res=%0d need all 0",
                 tag, s, cur_rdy, cur_busy, cur_fin, cur_ovf, cur_res);
      end
    end
  endtask

  int spec_rows[16];
  int sat_rows[16];

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 check_reset_state("reset_state");
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic test_spec_rows();
    sel = 0;
    run_solve(spec_rows, 1'b0, 1'b0, 1'b0);
    checks++;
    if (cur_res !== 16'd3) begin errors++; $display("FAIL spec_mode0 got=%0d need=3", cur_res); end
    repeat (3) @(posedge clk);
    #1 checks++;
    if (cur_fin !== 1'b1 || cur_res !== 16'd3) begin
      errors++; $display("FAIL done_hold got fin=%b res=%0d need fin=1 res=3", cur_fin, cur_res);
    end
    run_solve(spec_rows, 1'b1, 1'b0, 1'b1);
    checks++;
    if (cur_res !== 16'd4) begin errors++; $display("FAIL spec_mode1 got=%0d need=4", cur_res); end
  endtask

  task automatic test_gaps();
    sel = 0;
    run_solve(spec_rows, 1'b0, 1'b1, 1'b0);
    run_solve(spec_rows, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_left_edge();
    int rows[16];
    rows    = '{default: 0};
    rows[0] = 1;
    sel = 1;
    run_solve(rows, 1'b1, 1'b0, 1'b0);
    checks++;
    if (cur_res !== 16'd1) begin errors++; $display("FAIL left_edge got=%0d need=1", cur_res); end
    run_solve(rows, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_saturation();
    sel = 2;
    run_solve(sat_rows, 1'b1, 1'b0, 1'b0);
    checks++;
    if (cur_ovf !== 1'b1) begin errors++; $display("FAIL saturation_ovf got=%b need=1", cur_ovf); end
    run_solve(sat_rows, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_start_during_load();
    sel = 0;
    pulse_start(1'b0, 1'b0);
    send_beat(4'(spec_rows[0] & 15), 1'b0);
    pulse_start(1'b1, 1'b0);
    checks++;
    if (cur_rdy !== 1'b1 || cur_busy !== 1'b1) begin
      errors++; $display("FAIL start_in_load got rdy=%b busy=%b need 1 1", cur_rdy, cur_busy);
    end
    send_beat(4'((spec_rows[0] >> 4) & 7), 1'b0);
    checks++;
    if (cur_rdy !== 1'b0) begin errors++; $display("FAIL start_in_load_beat got rdy=%b need=0", cur_rdy); end
    @(posedge clk); #1;
    send_rows(spec_rows, 1, 1'b0);
    wait_done(1'b0);
    check_result(spec_rows, 1'b0);
  endtask

  task automatic test_rst_mid();
    sel = 0;
    pulse_start(1'b1, 1'b0);
    send_beat(4'hF, 1'b0);
    send_beat(4'h7, 1'b0);
    @(posedge clk); #1;
    send_beat(4'hA, 1'b0);
    @(negedge clk) rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 check_reset_state("rst_mid_row");
    @(negedge clk) rst = 1'b0;
    sel = 0;
    run_solve(spec_rows, 1'b1, 1'b0, 1'b0);
    sel = 2;
    pulse_start(1'b1, 1'b0);
    repeat (5) send_beat(4'($urandom), 1'b0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1 check_reset_state("rst_mid_reduce_path");
    @(negedge clk) rst = 1'b0;
    sel = 2;
    run_solve(sat_rows, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    int rows[16];
    for (int it = 0; it < 24; it++) begin
      for (int r = 0; r < 16; r++) rows[r] = int'($urandom_range(0, 127));
      sel = (it % 3 == 2) ? 2 : ((it % 5 == 4) ? 1 : 0);
      run_solve(rows, 1'($urandom), 1'($urandom), 1'($urandom));
    end
  endtask

  initial begin
    spec_rows = '{default: 0};
    spec_rows[1] = 8;
    spec_rows[2] = 20;
    sat_rows = '{default: 0};
    sat_rows[0] = 8;
    sat_rows[1] = 20;
    sat_rows[2] = 42;
    sat_rows[3] = 85;
    sat_rows[4] = 42;
    sat_rows[5] = 85;

    test_reset();
    test_spec_rows();
    test_gaps();
    test_left_edge();
    test_saturation();
    test_start_during_load();
    test_rst_mid();
    test_random();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1);
  end

endmodule
`default_nettype wire
